// File: rtl/parity_frame_checker.sv
// Deserialises one LSB-first serial frame of DATA_BITS data bits plus a trailing parity bit and checks its parity.
// Latency: frame_done rises 1 cycle after the parity bit is accepted, so a frame takes at least DATA_BITS+3 cycles from start.
// Backpressure: none. bit_valid=0 stalls the frame indefinitely with no timeout, and start is ignored while busy.
//
// Ports:
//   clk, rst    - rising-edge clock and synchronous active-high reset
//   start       - begin a frame (only looked at in IDLE)
//   bit_valid   - bit_in carries a serial bit this cycle
//   bit_in      - serial bit: data LSB first, then the parity bit
//   busy        - high whenever the FSM is not in IDLE
//   data_out    - parallel data of the last completed frame
//   parity_out  - expected parity bit of the last completed frame
//   parity_err  - last completed frame failed its parity check
//   frame_done  - one-cycle pulse marking a completed frame
module parity_frame_checker #(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_out,
    output logic                 parity_err,
    output logic                 frame_done
);

    // The counter is wide enough to hold DATA_BITS itself, so it never wraps within a frame.
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          count;
    logic                   acc;
    logic [DATA_BITS-1:0]   shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_valid && (count == LAST_IDX)) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // Result registers are loaded on the edge that accepts the parity bit, so
    // they already hold the new frame's values during the frame_done cycle and
    // stay put until the next completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            acc        <= 1'b0;
            shreg      <= '0;
            data_out   <= '0;
            parity_out <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        acc   <= 1'b0;
                        shreg <= '0;
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        // Shifting in from the top means that after DATA_BITS bits
                        // the first (LSB) bit ends up at index 0.
                        shreg <= {bit_in, shreg[DATA_BITS-1:1]};
                        acc   <= acc ^ bit_in;
                        count <= count + CW'(1);
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        data_out   <= shreg;
                        parity_out <= acc ^ ODD_PARITY;
                        parity_err <= acc ^ bit_in ^ ODD_PARITY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
